tictactoe_board_ctrl: RTL and testbench
=======================================

// Module: tictactoe_board_ctrl
// PURPOSE
//  Consumes the packed 18-bit press vector from the input collector (cell i -> bits [2i:2i-1]; bit 2i-1 = player-1
//  button, bit 2i = player-2 button). Synchronises and edge-detects presses, enforces turn order and cell occupancy,
//  holds the board, and detects win/draw. Feeds the display/LED stage with board, turn and result.
// PARAMETERS
//  SYNC_STAGES   2   flop stages on press[] and new_game before edge detection (legal range 2..4)
//  FIRST_PLAYER  1   player to move after reset/new game (1 or 2)
// PORTS
//  clk       in   1    system clock, all logic on rising edge
//  rst_n     in   1    asynchronous active-low reset
//  press     in   18   raw packed button levels, async to clk
//  new_game  in   1    raw level; rising edge restarts the game
//  board     out  18   cell i at [2i:2i-1]: 00 empty, 01 P1, 10 P2 (11 never driven)
//  turn      out  2    one-hot player to move (01 P1, 10 P2); 00 while game over
//  winner    out  2    01/10 once a player wins; else 00
//  win_line  out  9    bit i-1 set for each cell i in the winning line(s); else 0
//  draw      out  1    high in DRAW state
//  illegal   out  1    one-cycle pulse on a rejected press
//  move_cnt  out  4    accepted moves this game, 0..9
// BEHAVIOUR
//  Reset (rst_n=0, async): board=0, turn=FIRST_PLAYER one-hot, winner=0, win_line=0, draw=0, illegal=0, move_cnt=0,
//   sync/edge flops=0, state=PLAY. A new_game edge is required after DUT leaves reset only to restart a game, not to play.
//  Input path: each press bit and new_game pass SYNC_STAGES flops; a prev register holds the last synced value;
//   rise = synced & ~prev. A held button yields exactly one rise.
//  FSM states PLAY, CHECK, WIN, DRAW.
//  PLAY, cycle N with rise != 0:
//   - valid iff exactly one rise bit set, its player matches turn, target cell == 00.
//   - valid: at edge N+1 write cell, move_cnt+1, state->CHECK.
//   - invalid (>1 rise bits, wrong player, occupied cell): board unchanged, illegal=1 during cycle N+1 only.
//  CHECK (exactly one cycle): evaluate 3 rows, 3 columns, 2 diagonals on the registered board for the mover.
//   - any line complete: state->WIN, winner=mover, win_line=OR of all complete lines (double line at move 9 reports both).
//   - else move_cnt==9: state->DRAW, draw=1.
//   - else toggle turn, state->PLAY. Rises arriving during CHECK are dropped (no illegal).
//   Result visible at edge N+2 after the accepting cycle N. Win on move 9 takes precedence over draw.
//  WIN/DRAW: turn=00; all press rises ignored, no illegal; outputs hold until new_game rise.
//  new_game rise in any state: next edge clears board, winner, win_line, draw, move_cnt; turn=FIRST_PLAYER; state->PLAY.
//   Takes priority over a press rise in the same cycle (press discarded, no illegal).
//  Reset mid-operation: all state returns to reset values immediately; no partial move survives.
//  Raw press changing faster than SYNC_STAGES cycles is not guaranteed; debounce lives upstream.
// TESTING
//  1 Reset, P1 press cell 5 (bit 9) -> 2+SYNC_STAGES cycles later board[10:9]=01, move_cnt=1, turn=10.
//  2 P2 presses cell 5 (bit 10) after test 1 -> illegal one-cycle pulse, board unchanged, turn stays 10.
//  3 P1 presses cell 1 when turn=10 -> illegal pulse; simultaneous rises on cells 2 and 3 -> illegal, no write.
//  4 P1 cells 1,2,3 vs P2 cells 4,5 -> winner=01, win_line=9'b000000111, turn=00; later presses ignored.
//  5 Full board X O X / X O O / O X X -> after move 9 draw=1, winner=00; new_game rise -> board=0, turn=01.
//  6 Hold cell-7 P1 button 20 cycles -> single accept; assert rst_n low mid-CHECK -> all outputs at reset values.

Source files
------------

// File: rtl/tictactoe_board_ctrl_if.sv
// Press/board bus between the input collector, the board controller and the display stage.
interface tictactoe_board_ctrl_if;
    logic [18:1] press;
    logic        new_game;
    logic [18:1] board;
    logic [1:0]  turn;
    logic [1:0]  winner;
    logic [8:0]  win_line;
    logic        draw;
    logic        illegal;
    logic [3:0]  move_cnt;

    modport master (
        output press, new_game,
        input  board, turn, winner, win_line, draw, illegal, move_cnt
    );

    modport slave (
        input  press, new_game,
        output board, turn, winner, win_line, draw, illegal, move_cnt
    );
endinterface

// File: rtl/tictactoe_board_ctrl.sv
// Tic-tac-toe board controller: synchronises raw presses, enforces turns, holds the board, detects win/draw.
//  state   | meaning
//  S_PLAY  | waiting for a press from the player to move
//  S_CHECK | one cycle evaluating lines for the player who just moved
//  S_WIN   | game won, board frozen until new_game
//  S_DRAW  | board full without a line, frozen until new_game
module tictactoe_board_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int FIRST_PLAYER = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tictactoe_board_ctrl_if.slave bus
);

    localparam logic [1:0] FP_CODE = (FIRST_PLAYER == 2) ? 2'b10 : 2'b01;
    localparam logic [8:0] LINE_MASK [8] = '{9'h007, 9'h038, 9'h1C0,
                                             9'h049, 9'h092, 9'h124,
                                             9'h111, 9'h054};

    typedef enum logic [1:0] {S_PLAY, S_CHECK, S_WIN, S_DRAW} state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0][18:0] r_sync;
    logic [18:0]                  r_prev;
    logic [18:0]                  w_raw;
    logic [18:0]                  w_rise;
    logic [18:1]                  w_press_rise;
    logic                         w_ng_rise;

    logic [9:1][1:0] r_board;
    logic [1:0]      r_turn;
    logic [1:0]      r_winner;
    logic [8:0]      r_win_line;
    logic            r_illegal;
    logic [3:0]      r_move_cnt;

    logic [3:0] w_sel_cell;
    logic       w_sel_p2;
    logic       w_sel_occ;
    logic       w_multi;
    logic       w_valid;
    logic       w_accept;
    logic       w_reject;
    logic [8:0] w_mine;
    logic [8:0] w_win_mask;
    logic       w_hit;

    // new_game rides in bit 0 so one synchroniser chain serves all 19 inputs
    assign w_raw        = {bus.press, bus.new_game};
    assign w_rise       = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_press_rise = w_rise[18:1];
    assign w_ng_rise    = w_rise[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        w_sel_cell = 4'd0;
        w_sel_p2   = 1'b0;
        w_sel_occ  = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (w_press_rise[k]) begin
                w_sel_cell = 4'((k + 1) / 2);
                w_sel_p2   = ((k % 2) == 0);
                w_sel_occ  = (r_board[4'((k + 1) / 2)] != 2'b00);
            end
        end
    end

    assign w_multi  = |(w_press_rise & (w_press_rise - 18'd1));
    assign w_valid  = (|w_press_rise) && !w_multi && !w_sel_occ &&
                      (w_sel_p2 ? (r_turn == 2'b10) : (r_turn == 2'b01));
    assign w_accept = (r_state == S_PLAY) && !w_ng_rise && w_valid;
    assign w_reject = (r_state == S_PLAY) && !w_ng_rise && (|w_press_rise) && !w_valid;

    // Player codes on the board coincide with the one-hot turn encoding
    always_comb begin
        w_mine     = '0;
        w_win_mask = '0;
        for (int c = 0; c < 9; c++) begin
            w_mine[c] = (r_board[4'(c + 1)] == r_turn);
        end
        for (int l = 0; l < 8; l++) begin
            if ((w_mine & LINE_MASK[l]) == LINE_MASK[l]) begin
                w_win_mask = w_win_mask | LINE_MASK[l];
            end
        end
    end

    assign w_hit = |w_win_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PLAY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_ng_rise) begin
            w_next = S_PLAY;
        end else begin
            case (r_state)
                S_PLAY:  if (w_accept) w_next = S_CHECK;
                S_CHECK: begin
                    if (w_hit)                     w_next = S_WIN;
                    else if (r_move_cnt == 4'd9)   w_next = S_DRAW;
                    else                           w_next = S_PLAY;
                end
                S_WIN:   w_next = S_WIN;
                S_DRAW:  w_next = S_DRAW;
                default: w_next = S_PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board    <= '0;
            r_turn     <= FP_CODE;
            r_winner   <= 2'b00;
            r_win_line <= '0;
            r_illegal  <= 1'b0;
            r_move_cnt <= 4'd0;
        end else begin
            r_illegal <= w_reject;
            if (w_ng_rise) begin
                r_board    <= '0;
                r_turn     <= FP_CODE;
                r_winner   <= 2'b00;
                r_win_line <= '0;
                r_move_cnt <= 4'd0;
            end else begin
                case (r_state)
                    S_PLAY: begin
                        if (w_accept) begin
                            r_board[w_sel_cell] <= w_sel_p2 ? 2'b10 : 2'b01;
                            r_move_cnt          <= r_move_cnt + 4'd1;
                        end
                    end
                    S_CHECK: begin
                        if (w_hit) begin
                            r_winner   <= r_turn;
                            r_win_line <= w_win_mask;
                        end else if (r_move_cnt != 4'd9) begin
                            r_turn <= ~r_turn;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.turn = 2'b00;
        bus.draw = 1'b0;
        case (r_state)
            S_PLAY, S_CHECK: bus.turn = r_turn;
            S_DRAW:          bus.draw = 1'b1;
            default:         ;
        endcase
    end

    assign bus.board    = r_board;
    assign bus.winner   = r_winner;
    assign bus.win_line = r_win_line;
    assign bus.illegal  = r_illegal;
    assign bus.move_cnt = r_move_cnt;

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Directed plus randomized game play against a cell-array model of the tic-tac-toe rules.
module tb_tictactoe_board_ctrl;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tictactoe_board_ctrl_if bus();

    tictactoe_board_ctrl #(.SYNC_STAGES(SYNC), .FIRST_PLAYER(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int ill_cnt;

    int         m_cell [1:9];
    int         m_turn, m_winner, m_cnt, m_ill;
    logic [8:0] m_line;
    bit         m_draw;
    int         lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                                 '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:1] pv(input int c, input int p);
        logic [18:1] v;
        v = '0;
        v[2*c - 2 + p] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 1; c <= 9; c++) m_cell[c] = 0;
        m_turn = 1; m_winner = 0; m_cnt = 0; m_line = '0; m_draw = 0; m_ill = 0;
    endtask

    task automatic model_apply(input logic [18:1] vec);
        int k, c, p;
        m_ill = 0;
        if (m_winner != 0 || m_draw) return;
        if ($countones(vec) == 0) return;
        if ($countones(vec) > 1) begin m_ill = 1; return; end
        k = 0;
        for (int b = 1; b <= 18; b++) if (vec[b]) k = b;
        c = (k + 1) / 2;
        p = (k % 2 == 1) ? 1 : 2;
        if (p != m_turn || m_cell[c] != 0) begin m_ill = 1; return; end
        m_cell[c] = p;
        m_cnt++;
        for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] == p && m_cell[lines[l][1]] == p && m_cell[lines[l][2]] == p)
                m_line = m_line | (9'b1 << (lines[l][0]-1)) | (9'b1 << (lines[l][1]-1)) | (9'b1 << (lines[l][2]-1));
        if (m_line != 0) m_winner = p;
        else if (m_cnt == 9) m_draw = 1;
        else m_turn = 3 - p;
    endtask

    task automatic check_all(input string tag);
        logic [18:1] eb;
        logic [1:0]  et;
        eb = '0;
        for (int c = 1; c <= 9; c++) begin
            if (m_cell[c] == 1) eb[2*c-1] = 1'b1;
            if (m_cell[c] == 2) eb[2*c]   = 1'b1;
        end
        et = (m_winner != 0 || m_draw) ? 2'b00 : ((m_turn == 1) ? 2'b01 : 2'b10);
        check({tag, "/board"},    bus.board,    eb);
        check({tag, "/turn"},     bus.turn,     et);
        check({tag, "/winner"},   bus.winner,   m_winner[1:0]);
        check({tag, "/win_line"}, bus.win_line, m_line);
        check({tag, "/draw"},     bus.draw,     m_draw);
        check({tag, "/move_cnt"}, bus.move_cnt, m_cnt[3:0]);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus.illegal === 1'b1) ill_cnt++;
        end
    endtask

    task automatic step(input logic [18:1] vec, input int hold, input string tag);
        ill_cnt = 0;
        bus.press = vec;
        wait_cyc(hold);
        bus.press = '0;
        wait_cyc(SYNC + 4);
        model_apply(vec);
        check_all(tag);
        check({tag, "/illegal_cycles"}, ill_cnt, m_ill);
    endtask

    task automatic new_game(input string tag);
        ill_cnt = 0;
        bus.new_game = 1'b1;
        wait_cyc(SYNC + 3);
        bus.new_game = 1'b0;
        wait_cyc(SYNC + 2);
        model_reset();
        check_all(tag);
        check({tag, "/illegal_cycles"}, ill_cnt, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, c, p, r;
        logic [18:1] v;

        bus.press = '0;
        bus.new_game = 1'b0;
        rst_n = 1'b0;
        model_reset();
        ill_cnt = 0;
        wait_cyc(3);
        check_all("reset");
        check("reset/illegal", bus.illegal, 1'b0);
        rst_n = 1'b1;
        wait_cyc(2);

        // Test 1: latency of the first accepted move
        bus.press = pv(5, 1);
        lat = 0;
        while (bus.turn !== 2'b10 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t1/turn_latency", lat, SYNC + 2);
        bus.press = '0;
        ill_cnt = 0;
        wait_cyc(SYNC + 4);
        model_apply(pv(5, 1));
        check_all("t1");
        check("t1/illegal_cycles", ill_cnt, 0);

        step(pv(5, 2), SYNC + 3, "t2_occupied");
        step(pv(1, 1), SYNC + 3, "t3_wrong_player");
        step(pv(2, 2) | pv(3, 2), SYNC + 3, "t3_double");

        // Test 4: P1 takes the top row
        new_game("t4_ng");
        step(pv(1, 1), SYNC + 3, "t4_m1");
        step(pv(4, 2), SYNC + 3, "t4_m2");
        step(pv(2, 1), SYNC + 3, "t4_m3");
        step(pv(5, 2), SYNC + 3, "t4_m4");
        step(pv(3, 1), SYNC + 3, "t4_win");
        check("t4/win_line_const", bus.win_line, 9'b000000111);
        step(pv(6, 2), SYNC + 3, "t4_ignored");
        step(pv(7, 2) | pv(8, 1), SYNC + 3, "t4_ignored_double");

        // new_game and press rising together: press is discarded
        new_game("prio_ng");
        step(pv(1, 1), SYNC + 3, "prio_m1");
        ill_cnt = 0;
        bus.press = pv(2, 2);
        bus.new_game = 1'b1;
        wait_cyc(SYNC + 3);
        bus.press = '0;
        bus.new_game = 1'b0;
        wait_cyc(SYNC + 3);
        model_reset();
        check_all("prio");
        check("prio/illegal_cycles", ill_cnt, 0);

        // Test 5: X O X / X O O / O X X
        step(pv(1, 1), SYNC + 3, "t5_m1");
        step(pv(2, 2), SYNC + 3, "t5_m2");
        step(pv(3, 1), SYNC + 3, "t5_m3");
        step(pv(5, 2), SYNC + 3, "t5_m4");
        step(pv(4, 1), SYNC + 3, "t5_m5");
        step(pv(6, 2), SYNC + 3, "t5_m6");
        step(pv(8, 1), SYNC + 3, "t5_m7");
        step(pv(7, 2), SYNC + 3, "t5_m8");
        step(pv(9, 1), SYNC + 3, "t5_draw");
        check("t5/draw_const", bus.draw, 1'b1);
        step(pv(1, 2), SYNC + 3, "t5_ignored");
        new_game("t5_ng");

        // Test 6: long hold gives one move, then reset lands mid-CHECK
        step(pv(7, 1), 20, "t6_hold");
        bus.press = pv(1, 2);
        lat = 0;
        while (bus.move_cnt !== 4'd2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t6/reach_check", (lat < 20), 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_rst");
        check("t6_rst/illegal", bus.illegal, 1'b0);
        bus.press = '0;
        wait_cyc(SYNC + 2);
        rst_n = 1'b1;
        ill_cnt = 0;
        wait_cyc(SYNC + 4);
        check_all("t6_after");
        check("t6_after/illegal_cycles", ill_cnt, 0);

        // Randomized games
        for (int g = 0; g < 6; g++) begin
            new_game("rnd_ng");
            for (int s = 0; s < 12; s++) begin
                c = $urandom_range(1, 9);
                r = $urandom_range(0, 9);
                if (r < 6) p = (m_turn == 2) ? 2 : 1;
                else       p = $urandom_range(1, 2);
                v = pv(c, p);
                if (r == 9) v = v | pv($urandom_range(1, 9), $urandom_range(1, 2));
                step(v, SYNC + 3, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
